// File: rtl/exec_pkg.sv
// Shared types and field map for the execute sequencer.
// Holds opcode/state enums, field LSBs and opcode class helpers.
package exec_pkg;

   localparam int DEF_DATA_W  = 8;
   localparam int DEF_REG_AW  = 3;
   localparam int DEF_INSTR_W = 16;

   localparam int OP_LSB  = 12;
   localparam int OP_MSB  = 15;
   localparam int RD_LSB  = 9;
   localparam int RS1_LSB = 6;
   localparam int RS2_LSB = 3;
   localparam int IMM_LSB = 0;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_ADD  = 4'h1,
      OP_SUB  = 4'h2,
      OP_AND  = 4'h3,
      OP_OR   = 4'h4,
      OP_XOR  = 4'h5,
      OP_MOV  = 4'h6,
      OP_LDI  = 4'h7,
      OP_SHL  = 4'h8,
      OP_SHR  = 4'h9,
      OP_HALT = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_READ = 3'd1,
      ST_EXEC = 3'd2,
      ST_WB   = 3'd3,
      ST_HALT = 3'd4
   } state_e;

   // Ops that need the register file read path.
   function automatic logic uses_rf(
      input logic [3:0] op
   );
      return op inside {
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_XOR, OP_MOV, OP_SHL, OP_SHR
      };
   endfunction

   function automatic logic is_illegal(
      input logic [3:0] op
   );
      return op inside {[4'hA:4'hE]};
   endfunction

endpackage

// File: rtl/exec_sequencer_alu8.sv
// Combinational ALU: {op, a, b} -> {y, c}.
// Ports: op (4b opcode), a/b operands, y result, c carry/borrow/shift-out.
module exec_sequencer_alu8
   import exec_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] y,
   output logic              c
);

   logic [DATA_W:0] sum;

   assign sum = {1'b0, a} + {1'b0, b};

   always_comb begin
      y = '0;
      c = 1'b0;
      unique case (op)
         OP_ADD: begin
            y = sum[DATA_W-1:0];
            c = sum[DATA_W];
         end
         OP_SUB: begin
            y = a - b;
            c = (a < b);
         end
         OP_AND: y = a & b;
         OP_OR:  y = a | b;
         OP_XOR: y = a ^ b;
         OP_MOV: y = a;
         OP_SHL: begin
            y = {a[DATA_W-2:0], 1'b0};
            c = a[DATA_W-1];
         end
         OP_SHR: begin
            y = {1'b0, a[DATA_W-1:1]};
            c = a[0];
         end
         default: begin
            y = '0;
            c = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle execute stage driving a registered-read register file.
// Ports: instr valid/ready in, rf a1/a2/rd1/rd2 read, a3/we3/wd3 write, flags, status pulses.
module exec_sequencer
   import exec_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int REG_AW  = DEF_REG_AW,
   parameter int INSTR_W = DEF_INSTR_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instr,
   output logic               instr_ready,
   output logic [REG_AW-1:0]  rf_a1,
   output logic [REG_AW-1:0]  rf_a2,
   input  logic [DATA_W-1:0]  rf_rd1,
   input  logic [DATA_W-1:0]  rf_rd2,
   output logic [REG_AW-1:0]  rf_a3,
   output logic               rf_we3,
   output logic [DATA_W-1:0]  rf_wd3,
   output logic               flag_z,
   output logic               flag_c,
   output logic               busy,
   output logic               instr_done,
   output logic               illegal,
   output logic               halted
);

   state_e              state;
   state_e              nstate;
   logic [INSTR_W-1:0]  ir;
   logic [DATA_W-1:0]   res;
   logic                fz;
   logic                fc;

   logic [3:0]          new_op;
   logic [3:0]          cur_op;
   logic                accept;
   logic                quick;
   logic [DATA_W-1:0]   alu_y;
   logic                alu_c;
   logic                unused_ir;

   assign new_op = instr[OP_LSB +: 4];
   assign cur_op = ir[OP_LSB +: 4];
   assign accept = instr_valid
                 & (state == ST_IDLE);

   // Ops that finish in the accept cycle itself.
   assign quick = (new_op == OP_NOP)
                | is_illegal(new_op)
                | (new_op == OP_HALT);

   // Immediate is taken straight from the bus.
   assign unused_ir = ^ir[RS2_LSB-1:0];

   exec_sequencer_alu8 #(
      .DATA_W (DATA_W)
   ) u_alu (
      .op (cur_op),
      .a  (rf_rd1),
      .b  (rf_rd2),
      .y  (alu_y),
      .c  (alu_c)
   );

   always_comb begin
      nstate = state;
      unique case (state)
         ST_IDLE: begin
            if (instr_valid) begin
               unique case (1'b1)
                  uses_rf(new_op):
                     nstate = ST_READ;
                  (new_op == OP_LDI):
                     nstate = ST_WB;
                  (new_op == OP_HALT):
                     nstate = ST_HALT;
                  default:
                     nstate = ST_IDLE;
               endcase
            end
         end
         ST_READ: nstate = ST_EXEC;
         ST_EXEC: nstate = ST_WB;
         ST_WB:   nstate = ST_IDLE;
         ST_HALT: nstate = ST_HALT;
         default: nstate = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         ir    <= '0;
         res   <= '0;
         fz    <= 1'b0;
         fc    <= 1'b0;
      end else begin
         state <= nstate;
         if (accept) begin
            ir <= instr;
         end
         if (accept && (new_op == OP_LDI)) begin
            res <= instr[IMM_LSB +: DATA_W];
         end
         if (state == ST_EXEC) begin
            res <= alu_y;
            fz  <= (alu_y == '0);
            fc  <= alu_c;
         end
      end
   end

   assign instr_ready = (state == ST_IDLE);
   assign busy        = (state != ST_IDLE);
   assign rf_we3      = (state == ST_WB);
   assign halted      = (state == ST_HALT);
   assign instr_done  = (state == ST_WB)
                      | (accept & quick);
   assign illegal     = accept
                      & is_illegal(new_op);

   assign rf_a1  = ir[RS1_LSB +: REG_AW];
   assign rf_a2  = ir[RS2_LSB +: REG_AW];
   assign rf_a3  = ir[RD_LSB +: REG_AW];
   assign rf_wd3 = res;
   assign flag_z = fz;
   assign flag_c = fc;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a registered-read 8x8 register file.
// Writes are checked against a scoreboard filled at each accept.
module tb_exec_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic [15:0] instr = '0;
   logic        instr_ready;
   logic [2:0]  rf_a1, rf_a2, rf_a3;
   logic [7:0]  rf_rd1, rf_rd2, rf_wd3;
   logic        rf_we3, flag_z, flag_c;
   logic        busy, instr_done, illegal, halted;

   logic [7:0]  rf   [8];
   logic [7:0]  m_rf [8];
   logic        m_z = 1'b0;
   logic        m_c = 1'b0;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int n_done = 0;
   int n_acc  = 0;
   int n_we   = 0;

   typedef struct {
      logic [2:0] a;
      logic [7:0] d;
      logic       z;
      logic       c;
      int         lat;
      int         acc;
   } exp_t;

   exp_t sb[$];

   exec_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .rf_a1       (rf_a1),
      .rf_a2       (rf_a2),
      .rf_rd1      (rf_rd1),
      .rf_rd2      (rf_rd2),
      .rf_a3       (rf_a3),
      .rf_we3      (rf_we3),
      .rf_wd3      (rf_wd3),
      .flag_z      (flag_z),
      .flag_c      (flag_c),
      .busy        (busy),
      .instr_done  (instr_done),
      .illegal     (illegal),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Register file: registered read, write at the edge.
   initial begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'(i);
      forever begin
         @(posedge clk);
         rf_rd1 <= rf[rf_a1];
         rf_rd2 <= rf[rf_a2];
         if (rf_we3) rf[rf_a3] <= rf_wd3;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: no summary reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h",
                tag, obs, exp);
      end
   endtask

   // Write-back monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (instr_done) n_done++;
            if (instr_valid && instr_ready) n_acc++;
            if (rf_we3) begin
               n_we++;
               if (sb.size() == 0) begin
                  chk("we3_unexpected", 32'(rf_we3), 0);
               end else begin
                  e = sb.pop_front();
                  chk("wb_a3", 32'(rf_a3), 32'(e.a));
                  chk("wb_wd3", 32'(rf_wd3), 32'(e.d));
                  chk("wb_z", 32'(flag_z), 32'(e.z));
                  chk("wb_c", 32'(flag_c), 32'(e.c));
                  chk("wb_lat", 32'(cyc - e.acc + 1),
                      32'(e.lat));
               end
            end
         end
      end
   end

   function automatic logic [15:0] enc(
      input int op, input int rd,
      input int rs1, input int rs2);
      return 16'((op << 12) | (rd << 9) |
                 (rs1 << 6) | (rs2 << 3));
   endfunction

   function automatic logic [15:0] ldi(
      input int rd, input int imm);
      return 16'((7 << 12) | (rd << 9) | imm);
   endfunction

   // Reference behaviour of one accepted instruction.
   task automatic predict(input logic [15:0] w,
                          input int acc);
      int op, a, b, r;
      logic c;
      logic [7:0] y;
      logic [2:0] rd;
      exp_t e;
      bit wr;
      op = int'(w[15:12]);
      rd = w[11:9];
      a  = int'(m_rf[w[8:6]]);
      b  = int'(m_rf[w[5:3]]);
      wr = 1'b1;
      r  = 0;
      c  = 1'b0;
      case (op)
         1: begin r = a + b; c = (r > 255); end
         2: begin r = a - b; c = (a < b); end
         3: r = a & b;
         4: r = a | b;
         5: r = a ^ b;
         6: r = a;
         7: r = int'(w[7:0]);
         8: begin r = a * 2; c = (a > 127); end
         9: begin r = a / 2; c = (a % 2 == 1); end
         default: wr = 1'b0;
      endcase
      if (wr) begin
         y = 8'(r);
         if (op != 7) begin
            m_z = (y == 8'h00);
            m_c = c;
         end
         m_rf[rd] = y;
         e.a   = rd;
         e.d   = y;
         e.z   = m_z;
         e.c   = m_c;
         e.lat = (op == 7) ? 1 : 3;
         e.acc = acc;
         sb.push_back(e);
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!instr_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ready_wait", 32'(instr_ready), 1);
   endtask

   task automatic issue(input logic [15:0] w);
      instr_valid = 1'b1;
      instr       = w;
      wait_ready();
      @(posedge clk); #1;
      predict(w, cyc);
      instr_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_wait", 32'(busy), 0);
   endtask

   initial begin
      logic [15:0] seq [6];
      logic [15:0] w;
      logic [7:0]  old6;
      int d0, a0, w0, n;

      for (int i = 0; i < 8; i++) m_rf[i] = 8'(i);

      // Reset values.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(instr_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_we3", 32'(rf_we3), 0);
      chk("rst_done", 32'(instr_done), 0);
      chk("rst_illegal", 32'(illegal), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_a1", 32'(rf_a1), 0);
      chk("rst_a2", 32'(rf_a2), 0);
      chk("rst_a3", 32'(rf_a3), 0);
      chk("rst_wd3", 32'(rf_wd3), 0);
      chk("rst_z", 32'(flag_z), 0);
      chk("rst_c", 32'(flag_c), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: LDI, LDI, ADD.
      issue(ldi(1, 8'h05));
      issue(ldi(2, 8'h03));
      issue(enc(1, 3, 1, 2));
      wait_idle();
      chk("t1_r3", 32'(rf[3]), 32'h08);
      chk("t1_z", 32'(flag_z), 0);
      chk("t1_c", 32'(flag_c), 0);

      // 2: overflow to zero, shift-out.
      issue(ldi(1, 8'hFF));
      issue(ldi(2, 8'h01));
      issue(enc(1, 4, 1, 2));
      issue(enc(8, 5, 1, 0));
      wait_idle();
      chk("t2_r4", 32'(rf[4]), 32'h00);
      chk("t2_r5", 32'(rf[5]), 32'hFE);

      // 3: borrow and equal-operand subtract.
      issue(ldi(3, 8'h03));
      issue(ldi(5, 8'h05));
      issue(enc(2, 6, 3, 5));
      issue(enc(2, 6, 5, 5));
      wait_idle();
      chk("t3_r6", 32'(rf[6]), 32'h00);
      chk("t3_z", 32'(flag_z), 1);
      chk("t3_c", 32'(flag_c), 0);

      // 4: valid held high across a mix.
      seq[0] = ldi(1, 8'h10);
      seq[1] = 16'h0000;
      seq[2] = enc(1, 2, 1, 1);
      seq[3] = enc(6, 3, 2, 0);
      seq[4] = 16'h0000;
      seq[5] = enc(5, 4, 3, 1);
      d0 = n_done;
      a0 = n_acc;
      instr_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         w = seq[i];
         instr = w;
         wait_ready();
         @(posedge clk); #1;
         predict(w, cyc);
         if (w[15:12] == 4'h0) begin
            chk("t4_nop_ready", 32'(instr_ready), 1);
         end
      end
      instr_valid = 1'b0;
      wait_idle();
      chk("t4_done_cnt", 32'(n_done - d0), 6);
      chk("t4_acc_cnt", 32'(n_acc - a0), 6);
      chk("t4_r4", 32'(rf[4]), 32'h30);

      // 5: illegal opcode, then HALT.
      d0 = n_done;
      w0 = n_we;
      instr = 16'hA000;
      instr_valid = 1'b1;
      #1;
      chk("t5_illegal", 32'(illegal), 1);
      chk("t5_ill_done", 32'(instr_done), 1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      #1;
      chk("t5_ill_pulse", 32'(illegal), 0);
      chk("t5_ill_idle", 32'(instr_ready), 1);
      instr = 16'hF000;
      instr_valid = 1'b1;
      #1;
      chk("t5_halt_done", 32'(instr_done), 1);
      @(posedge clk); #1;
      chk("t5_halted", 32'(halted), 1);
      chk("t5_hlt_ready", 32'(instr_ready), 0);
      instr = enc(1, 7, 1, 2);
      repeat (10) @(posedge clk);
      #1;
      instr_valid = 1'b0;
      chk("t5_done_cnt", 32'(n_done - d0), 2);
      chk("t5_we_cnt", 32'(n_we - w0), 0);
      chk("t5_sticky", 32'(halted), 1);

      // 6: reset during write-back.
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_z = 1'b0;
      m_c = 1'b0;
      chk("t6_unhalt", 32'(halted), 0);
      issue(ldi(1, 8'hFF));
      issue(ldi(2, 8'h02));
      wait_idle();
      old6 = m_rf[6];
      instr = enc(1, 6, 1, 2);
      instr_valid = 1'b1;
      wait_ready();
      @(posedge clk); #1;
      instr_valid = 1'b0;
      n = 0;
      while (!rf_we3 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("t6_wb_reach", 32'(rf_we3), 1);
      chk("t6_pre_c", 32'(flag_c), 1);
      chk("t6_pre_z", 32'(flag_z), 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_we3_drop", 32'(rf_we3), 0);
      @(posedge clk); #1;
      chk("t6_r6_kept", 32'(rf[6]), 32'(old6));
      rst_n = 1'b1;
      #1;
      chk("t6_ready", 32'(instr_ready), 1);
      chk("t6_busy", 32'(busy), 0);
      chk("t6_z", 32'(flag_z), 0);
      chk("t6_c", 32'(flag_c), 0);
      @(posedge clk); #1;

      chk("sb_empty", 32'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
